rgb_palette_lut: RTL and testbench
==================================

Name: rgb_palette_lut

Overview:
- Parametrised, run-time-writable colour palette that converts a colour index to a packed R/G/B word.
- Successor to the fixed 8-entry, 24-bit colour-to-RGB converter. Adds:
  - generic index and channel widths;
  - a write port for reprogramming entries;
  - a 2-stage registered read pipeline with a valid flag;
  - per-request brightness dimming.
- Sits between colour-index sources (pattern generators, LED drivers) and display/PWM back-ends.

Parameters:
- IDX_W, 3, index width; palette depth = 2**IDX_W entries.
- CH_W, 8, bits per colour channel; data word = 3*CH_W bits, packed {R,G,B}, R in the MSBs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  read request; colour and dim are sampled when high.
- colour  input  IDX_W  palette index to read.
- dim  input  2  brightness: 0 full, 1 half, 2 quarter, 3 off.
- wr_en  input  1  palette write strobe.
- wr_idx  input  IDX_W  entry to write.
- wr_rgb  input  3*CH_W  new entry value, {R,G,B}.
- rgb  output  3*CH_W  looked-up, dimmed colour.
- rgb_valid  output  1  rgb holds a new result this cycle.

Behaviour:
- Reset (rst high at a clock edge, takes priority over all other inputs):
  - Palette loads its defaults in that single edge. Entry i for i<8: R = all-ones if i[2], G = all-ones if i[1], B = all-ones if i[0], otherwise 0.
  - Default order: 0 black, 1 blue, 2 green, 3 cyan, 4 red, 5 magenta, 6 yellow, 7 white.
  - Entries 8 and above reset to 0.
  - If IDX_W<3, only entries 0..2**IDX_W-1 exist, using the same rule.
  - Pipeline valid bits clear; rgb=0; rgb_valid=0.
  - Writes and reads presented during reset are discarded.
- Write:
  - When wr_en is high and rst is low, palette[wr_idx] <= wr_rgb at the clock edge.
  - One write per cycle.
- Read pipeline, latency 2:
  - Stage 1 (edge N, enable=1): s1_data <= entry[colour]; s1_dim <= dim; s1_valid <= 1. If enable=0, s1_valid <= 0 and s1_data holds.
  - Stage 2 (edge N+1): if s1_valid, each channel of rgb <= channel >> s1_dim (dim=3 gives 0, not a shift by 3), and rgb_valid <= 1. Otherwise rgb holds and rgb_valid <= 0.
  - Dimming is a logical right shift per channel. Bits never cross channel boundaries.
- Read-during-write:
  - Same cycle, enable=1, wr_en=1, colour==wr_idx: stage 1 captures wr_rgb (write-first bypass).
  - Different indices: independent.
- Back-to-back:
  - enable held high gives one result per cycle; throughput is 1.
  - There is no backpressure; the consumer must accept rgb whenever rgb_valid=1.
- Reset mid-operation: in-flight requests are dropped; no rgb_valid pulse follows the reset edge.
- Out-of-range indices are impossible because depth is exactly 2**IDX_W.

Test Plan:
- Defaults: defaults, IDX_W=3, CH_W=8, rst 1 cycle then reads of indices 0..7 with dim=0, enable high for 8 cycles -> from cycle 2 after the first request, rgb = 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF on consecutive cycles, each with rgb_valid=1.
- Write then read: write idx 5 = 123456; read idx 5 two cycles later -> rgb=123456 two cycles after the read.
- Bypass: in the same cycle write idx 2 = ABCDEF and read idx 2 -> rgb=ABCDEF after latency 2, not 00FF00.
- Dimming: read idx 7 with dim=1, 2, 3 -> 7F7F7F, 3F3F3F, 000000. Also write idx 0 = 80FF01 then read with dim=1 -> 407F00, with no bit bleed between channels.
- Enable gaps: enable pattern 1,0,1 -> rgb_valid pattern 1,0,1 delayed by 2; rgb holds its value during the gap.
- Reset recovery and parametrisation: write idx 7 = 000001, assert rst while reads are in flight -> no rgb_valid for 2 cycles; a subsequent read of idx 7 returns FFFFFF. Re-run with IDX_W=4, CH_W=4 -> idx 7 = FFF, idx 12 = 000 after reset.

Source files
------------

// File: rtl/rgb_palette_lut.sv
// Run-time writable RGB palette: index -> packed {R,G,B} word through a 2-stage read pipeline
// with write-first bypass and per-request brightness dimming.
module rgb_palette_lut #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned CH_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [IDX_W-1:0]    colour,
    input  logic [1:0]          dim,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_rgb,
    output logic [3*CH_W-1:0]   rgb,
    output logic                rgb_valid
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int DW    = 3 * CH_W;

    // Entries 0..7 are the 3-bit primaries (bit2=R, bit1=G, bit0=B); higher entries are black.
    function automatic logic [DW-1:0] default_entry(input int idx);
        logic [2:0] b;
        if (idx >= 8) begin
            return '0;
        end
        b = 3'(idx);
        return {{CH_W{b[2]}}, {CH_W{b[1]}}, {CH_W{b[0]}}};
    endfunction

    // Shift by 3 must give zero rather than a 3-bit shift.
    function automatic logic [CH_W-1:0] dim_channel(input logic [CH_W-1:0] ch,
                                                    input logic [1:0]      d);
        logic [CH_W-1:0] res;
        unique case (d)
            2'd0:    res = ch;
            2'd1:    res = ch >> 1;
            2'd2:    res = ch >> 2;
            default: res = '0;
        endcase
        return res;
    endfunction

    logic [DW-1:0] r_pal [DEPTH];
    logic [DW-1:0] r_s1_data;
    logic [1:0]    r_s1_dim;
    logic          r_s1_valid;
    logic [DW-1:0] r_rgb;
    logic          r_rgb_valid;
    logic [DW-1:0] w_rd_data;
    logic [DW-1:0] w_dimmed;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pal[i] <= default_entry(i);
            end
        end else if (wr_en) begin
            r_pal[wr_idx] <= wr_rgb;
        end
    end

    always_comb begin
        w_rd_data = r_pal[colour];
        if (wr_en && (wr_idx == colour)) begin
            w_rd_data = wr_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_dim   <= '0;
        end else begin
            r_s1_valid <= enable;
            if (enable) begin
                r_s1_data <= w_rd_data;
                r_s1_dim  <= dim;
            end
        end
    end

    always_comb begin
        w_dimmed = '0;
        for (int c = 0; c < 3; c++) begin
            w_dimmed[c*CH_W +: CH_W] = dim_channel(r_s1_data[c*CH_W +: CH_W], r_s1_dim);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb       <= '0;
            r_rgb_valid <= 1'b0;
        end else begin
            r_rgb_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rgb <= w_dimmed;
            end
        end
    end

    assign rgb       = r_rgb;
    assign rgb_valid = r_rgb_valid;

endmodule

// File: tb/tb_rgb_palette_lut.sv
// Self-checking bench for rgb_palette_lut: directed plan plus random traffic against a
// cycle-scheduled palette model; a second 4-bit/4-bit instance checks parametrisation.
module tb_rgb_palette_lut;

    logic        clk = 1'b0;
    logic        rst, enable, wr_en;
    logic [2:0]  colour, wr_idx;
    logic [1:0]  dim;
    logic [23:0] wr_rgb, rgb;
    logic        rgb_valid;

    logic        rst4, enable4, wr_en4;
    logic [3:0]  colour4, wr_idx4;
    logic [1:0]  dim4;
    logic [11:0] wr_rgb4, rgb4;
    logic        rgb_valid4;

    always #5 clk = ~clk;

    rgb_palette_lut #(.IDX_W(3), .CH_W(8)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .colour(colour), .dim(dim),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_rgb(wr_rgb), .rgb(rgb), .rgb_valid(rgb_valid)
    );

    rgb_palette_lut #(.IDX_W(4), .CH_W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .enable(enable4), .colour(colour4), .dim(dim4),
        .wr_en(wr_en4), .wr_idx(wr_idx4), .wr_rgb(wr_rgb4), .rgb(rgb4), .rgb_valid(rgb_valid4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: palette contents plus results scheduled by the edge at which they must appear.
    logic [23:0] pal [8];
    logic        sched_v [0:1023];
    logic [23:0] sched_d [0:1023];
    logic [23:0] m_rgb = '0;
    logic        m_v   = 1'b0;
    int          cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [23:0] spec_default(input int i);
        logic [23:0] v;
        v = '0;
        if (i % 2 == 1)       v = v + 24'h0000FF;
        if ((i / 2) % 2 == 1) v = v + 24'h00FF00;
        if ((i / 4) % 2 == 1) v = v + 24'hFF0000;
        return v;
    endfunction

    function automatic logic [23:0] spec_dim(input logic [23:0] v, input int d);
        int r, g, b, div;
        if (d == 3) return 24'h0;
        div = 1 << d;
        r = int'(v[23:16]) / div;
        g = int'(v[15:8]) / div;
        b = int'(v[7:0]) / div;
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    task automatic step(input logic en, input logic [2:0] col, input logic [1:0] dm,
                        input logic we, input logic [2:0] widx, input logic [23:0] wrgb,
                        input logic rs);
        logic [23:0] val;
        @(negedge clk);
        rst = rs; enable = en; colour = col; dim = dm;
        wr_en = we; wr_idx = widx; wr_rgb = wrgb;
        @(posedge clk);
        cyc++;
        if (rs) begin
            for (int i = 0; i < 8; i++) pal[i] = spec_default(i);
            sched_v[cyc + 1] = 1'b0;
            m_v   = 1'b0;
            m_rgb = '0;
        end else begin
            val = (we && widx == col) ? wrgb : pal[col];
            sched_v[cyc + 1] = en;
            sched_d[cyc + 1] = spec_dim(val, int'(dm));
            if (we) pal[widx] = wrgb;
            m_v = sched_v[cyc];
            if (m_v) m_rgb = sched_d[cyc];
        end
        #1;
        check("rgb_valid", 32'(rgb_valid), 32'(m_v));
        check("rgb", 32'(rgb), 32'(m_rgb));
    endtask

    task automatic step4(input logic rs, input logic en, input logic [3:0] col,
                         input logic [1:0] dm);
        @(negedge clk);
        rst4 = rs; enable4 = en; colour4 = col; dim4 = dm;
        @(posedge clk);
        #1;
    endtask

    logic [23:0] dflt_tab [8];

    initial begin
        dflt_tab = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                     24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        for (int i = 0; i < 1024; i++) begin
            sched_v[i] = 1'b0;
            sched_d[i] = '0;
        end
        rst = 1'b1; enable = 1'b0; colour = '0; dim = '0; wr_en = 1'b0; wr_idx = '0;
        wr_rgb = '0;
        rst4 = 1'b1; enable4 = 1'b0; colour4 = '0; dim4 = '0; wr_en4 = 1'b0; wr_idx4 = '0;
        wr_rgb4 = '0;

        // Reset with a write and read presented: both must be discarded.
        step(1'b1, 3'd5, 2'd0, 1'b1, 3'd5, 24'h111111, 1'b1);
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_valid", 32'(rgb_valid), 32'h0);

        // Defaults 0..7 back to back.
        for (int i = 0; i < 9; i++) begin
            step(i < 8, 3'(i), 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
            if (i >= 1) check("default", 32'(rgb), 32'(dflt_tab[i - 1]));
        end
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);

        // Write then read.
        step(1'b0, 3'd0, 2'd0, 1'b1, 3'd5, 24'h123456, 1'b0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b1, 3'd5, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        check("write_read", 32'(rgb), 32'h123456);

        // Write-first bypass.
        step(1'b1, 3'd2, 2'd0, 1'b1, 3'd2, 24'hABCDEF, 1'b0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        check("bypass", 32'(rgb), 32'hABCDEF);

        // Dimming levels and channel isolation.
        step(1'b1, 3'd7, 2'd1, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b1, 3'd7, 2'd2, 1'b0, 3'd0, 24'h0, 1'b0);
        check("dim1", 32'(rgb), 32'h7F7F7F);
        step(1'b1, 3'd7, 2'd3, 1'b0, 3'd0, 24'h0, 1'b0);
        check("dim2", 32'(rgb), 32'h3F3F3F);
        step(1'b0, 3'd0, 2'd0, 1'b1, 3'd0, 24'h80FF01, 1'b0);
        check("dim3", 32'(rgb), 32'h000000);
        step(1'b1, 3'd0, 2'd1, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        check("dim_bleed", 32'(rgb), 32'h407F00);

        // Enable gap: valid follows 1,0,1 and rgb holds during the gap.
        step(1'b1, 3'd3, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b1, 3'd4, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        check("gap_valid", 32'(rgb_valid), 32'h0);
        check("gap_hold", 32'(rgb), 32'h00FFFF);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        check("gap_resume", 32'(rgb), 32'hFF0000);

        // Reset with reads in flight.
        step(1'b0, 3'd0, 2'd0, 1'b1, 3'd7, 24'h000001, 1'b0);
        step(1'b1, 3'd7, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b1, 3'd7, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b1, 3'd7, 2'd0, 1'b0, 3'd0, 24'h0, 1'b1);
        check("rst_drop0", 32'(rgb_valid), 32'h0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        check("rst_drop1", 32'(rgb_valid), 32'h0);
        step(1'b1, 3'd7, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 24'h0, 1'b0);
        check("rst_restore", 32'(rgb), 32'hFFFFFF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom), 2'($urandom),
                 1'($urandom_range(0, 2) == 0), 3'($urandom), 24'($urandom),
                 1'($urandom_range(0, 59) == 0));
        end

        // Wider palette, narrower channels.
        step4(1'b1, 1'b0, 4'd0, 2'd0);
        check("p4_reset_valid", 32'(rgb_valid4), 32'h0);
        step4(1'b0, 1'b1, 4'd7, 2'd0);
        step4(1'b0, 1'b1, 4'd12, 2'd0);
        check("p4_idx7", 32'(rgb4), 32'hFFF);
        check("p4_valid", 32'(rgb_valid4), 32'h1);
        step4(1'b0, 1'b1, 4'd5, 2'd1);
        check("p4_idx12", 32'(rgb4), 32'h000);
        step4(1'b0, 1'b0, 4'd0, 2'd0);
        check("p4_dim", 32'(rgb4), 32'h707);
        step4(1'b0, 1'b0, 4'd0, 2'd0);
        check("p4_idle", 32'(rgb_valid4), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
